// File: rtl/workout_disp_pkg.sv
// Shared types and constants for the workout display controller.
// Latency: none (types, constants and a pure combinational encoder only).
// Backpressure: none.
package workout_disp_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_W = 2'd1,
        CONV_T = 2'd2,
        LOAD   = 2'd3
    } conv_state_t;

    // Scan positions, left to right on the display
    localparam int         NUM_DIG = 5;
    localparam logic [2:0] DIG_W_H = 3'd0;   // workout hundreds
    localparam logic [2:0] DIG_W_T = 3'd1;   // workout tens
    localparam logic [2:0] DIG_W_U = 3'd2;   // workout units
    localparam logic [2:0] DIG_T_T = 3'd3;   // seconds tens
    localparam logic [2:0] DIG_T_U = 3'd4;   // seconds units

    // Segment pattern gfedcba, active-low; all segments off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // BCD digit to active-low segment pattern; non-decimal codes show blank
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one bit per cycle, MSB first.
// Latency: nbits cycles from the start cycle; done flags the final step, bcd is valid in that same cycle.
// Backpressure: none; a start while running restarts the conversion, caller keeps din/nbits stable during start.
module bin2bcd_seq #(
    parameter int IN_W = 8,
    parameter int DIG  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [IN_W-1:0]            din,
    input  logic [$clog2(IN_W+1)-1:0]  nbits,
    output logic                       done,
    output logic [4*DIG-1:0]           bcd
);
    localparam int CNT_W = $clog2(IN_W + 1);

    logic [4*DIG-1:0] bcd_r;
    logic [IN_W-1:0]  bin_r;
    logic [CNT_W-1:0] cnt;
    logic             active;

    logic [4*DIG-1:0] src_bcd;
    logic [4*DIG-1:0] adj_bcd;
    logic [IN_W-1:0]  src_bin;
    logic [CNT_W-1:0] src_cnt;
    logic [4*DIG-1:0] nxt_bcd;
    logic [IN_W-1:0]  nxt_bin;

    // One double-dabble step; on start the step works on the fresh operand so no load cycle is spent
    always_comb begin
        src_bcd = start ? '0    : bcd_r;
        src_bin = start ? din   : bin_r;
        src_cnt = start ? nbits : cnt;
        adj_bcd = src_bcd;
        for (int i = 0; i < DIG; i++) begin
            if (src_bcd[4*i +: 4] >= 4'd5) begin
                adj_bcd[4*i +: 4] = src_bcd[4*i +: 4] + 4'd3;
            end
        end
        {nxt_bcd, nxt_bin} = {adj_bcd, src_bin} << 1;
    end

    // A zero bit count never signals done; callers always request at least one step
    assign done = (start | active) && (src_cnt == CNT_W'(1));
    assign bcd  = nxt_bcd;

    // Shift register and remaining-step counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            bcd_r  <= '0;
            bin_r  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start || active) begin
            bcd_r  <= nxt_bcd;
            bin_r  <= nxt_bin;
            cnt    <= src_cnt - CNT_W'(1);
            active <= (src_cnt > CNT_W'(1));
        end
    end

endmodule

// File: rtl/workout_display_ctrl.sv
// Workout/seconds 5-digit multiplexed 7-seg driver with sequential BCD conversion and buzzer beep pattern.
// Latency: input change to display registers 16 cycles; seg/an registered (1 cycle); buzz_out 1 cycle after a buzzer rise.
// Backpressure: none; inputs changing mid-conversion are re-compared in IDLE. Option DISPLAY_ALARM_BLINK_EN blanks time digits in beep off-phases.
module workout_display_ctrl
    import workout_disp_pkg::*;
#(
    parameter int CLK_PER_DIGIT = 1000,
    parameter int BUZZ_BEEP_CYC = 50,
    parameter int BUZZ_BEEPS    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] workout_num,
    input  logic [5:0] time_remain,
    input  logic       buzzer,
    output logic [6:0] seg,
    output logic [4:0] an,
    output logic       buzz_out,
    output logic       busy
);
    localparam int DIV_W  = (CLK_PER_DIGIT > 1) ? $clog2(CLK_PER_DIGIT) : 1;
    localparam int PH_W   = (BUZZ_BEEP_CYC > 1) ? $clog2(BUZZ_BEEP_CYC) : 1;
    localparam int BEEP_W = (BUZZ_BEEPS > 1)    ? $clog2(BUZZ_BEEPS)    : 1;

    // ---------------- conversion sequencer ----------------
    conv_state_t state;
    logic [7:0]  snap_w;
    logic [5:0]  snap_t;
    logic        cv_start;
    logic [7:0]  cv_din;
    logic [3:0]  cv_nbits;
    logic        cv_done;
    logic [11:0] cv_bcd;
    logic [11:0] hold_w;
    logic [7:0]  hold_t;
    logic [3:0]  d_w_h, d_w_t, d_w_u, d_t_t, d_t_u;

    // Seconds are fed left-aligned so only their 6 significant bits are shifted
    assign cv_din   = (state == CONV_T) ? {snap_t, 2'b00} : snap_w;
    assign cv_nbits = (state == CONV_T) ? 4'd6 : 4'd8;

    bin2bcd_seq #(
        .IN_W (8),
        .DIG  (3)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (cv_start),
        .din   (cv_din),
        .nbits (cv_nbits),
        .done  (cv_done),
        .bcd   (cv_bcd)
    );

    // Snapshot inputs, convert workout then seconds, then commit all five digits at once
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            snap_w   <= '0;
            snap_t   <= '0;
            cv_start <= 1'b0;
            busy     <= 1'b0;
            hold_w   <= '0;
            hold_t   <= '0;
            d_w_h    <= '0;
            d_w_t    <= '0;
            d_w_u    <= '0;
            d_t_t    <= '0;
            d_t_u    <= '0;
        end else begin
            cv_start <= 1'b0;
            case (state)
                IDLE: begin
                    if ({workout_num, time_remain} != {snap_w, snap_t}) begin
                        snap_w   <= workout_num;
                        snap_t   <= time_remain;
                        cv_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CONV_W;
                    end
                end
                CONV_W: begin
                    if (cv_done) begin
                        hold_w   <= cv_bcd;
                        cv_start <= 1'b1;
                        state    <= CONV_T;
                    end
                end
                CONV_T: begin
                    if (cv_done) begin
                        hold_t <= cv_bcd[7:0];
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    d_w_h <= hold_w[11:8];
                    d_w_t <= hold_w[7:4];
                    d_w_u <= hold_w[3:0];
                    d_t_t <= hold_t[7:4];
                    d_t_u <= hold_t[3:0];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- buzzer pattern ----------------
    logic              buzz_prev;
    logic              buzz_rise;
    logic              pat_act;
    logic              ph_on;
    logic [PH_W-1:0]   ph_cnt;
    logic [BEEP_W-1:0] beep_cnt;

    assign buzz_rise = buzzer & ~buzz_prev;

    // Beep sequencer: a rise (re)starts at beep 1, on-phase then off-phase per beep
    always_ff @(posedge clk) begin
        if (!reset) begin
            buzz_prev <= 1'b0;
            pat_act   <= 1'b0;
            ph_on     <= 1'b0;
            ph_cnt    <= '0;
            beep_cnt  <= '0;
            buzz_out  <= 1'b0;
        end else begin
            buzz_prev <= buzzer;
            if (buzz_rise) begin
                pat_act  <= 1'b1;
                ph_on    <= 1'b1;
                ph_cnt   <= '0;
                beep_cnt <= '0;
                buzz_out <= 1'b1;
            end else if (pat_act) begin
                if (ph_cnt == PH_W'(BUZZ_BEEP_CYC - 1)) begin
                    ph_cnt <= '0;
                    if (ph_on) begin
                        ph_on    <= 1'b0;
                        buzz_out <= 1'b0;
                    end else if (beep_cnt == BEEP_W'(BUZZ_BEEPS - 1)) begin
                        pat_act <= 1'b0;
                    end else begin
                        beep_cnt <= beep_cnt + BEEP_W'(1);
                        ph_on    <= 1'b1;
                        buzz_out <= 1'b1;
                    end
                end else begin
                    ph_cnt <= ph_cnt + PH_W'(1);
                end
            end
        end
    end

    // ---------------- display scan ----------------
    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [3:0]       cur_dig;
    logic             cur_blank;
    logic             time_blank;

`ifdef DISPLAY_ALARM_BLINK_EN
    assign time_blank = pat_act & ~ph_on;
`else
    assign time_blank = 1'b0;
`endif

    // Dwell divider and digit index, wrapping after the last digit
    always_ff @(posedge clk) begin
        if (!reset) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(CLK_PER_DIGIT - 1)) begin
            div <= '0;
            idx <= (idx == 3'(NUM_DIG - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Pick the current digit and apply leading-zero (and optional alarm) blanking
    always_comb begin
        cur_dig   = d_w_u;
        cur_blank = 1'b0;
        case (idx)
            DIG_W_H: begin
                cur_dig   = d_w_h;
                cur_blank = (d_w_h == 4'd0);
            end
            DIG_W_T: begin
                cur_dig   = d_w_t;
                cur_blank = (d_w_h == 4'd0) && (d_w_t == 4'd0);
            end
            DIG_W_U: cur_dig = d_w_u;
            DIG_T_T: begin
                cur_dig   = d_t_t;
                cur_blank = time_blank;
            end
            DIG_T_U: begin
                cur_dig   = d_t_u;
                cur_blank = time_blank;
            end
            default: cur_blank = 1'b1;
        endcase
    end

    // seg and an registered together so segment data never leads or lags its digit enable
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= 5'h1F;
        end else begin
            seg <= cur_blank ? SEG_BLANK : seg_enc(cur_dig);
            an  <= ~(5'b00001 << idx);
        end
    end

endmodule

// File: tb/tb_workout_display_ctrl.sv
// Self-checking bench: directed cases plus random traffic against a behavioural model.
// Latency: model checks every output every cycle, sampled 1 time unit after the clock edge.
// Backpressure: none.
module tb_workout_display_ctrl;
    localparam int CPD   = 4;
    localparam int BCYC  = 3;
    localparam int BNUM  = 3;
    localparam int CONV_LAT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] workout_num;
    logic [5:0] time_remain;
    logic       buzzer;
    logic [6:0] seg;
    logic [4:0] an;
    logic       buzz_out;
    logic       busy;

    workout_display_ctrl #(
        .CLK_PER_DIGIT (CPD),
        .BUZZ_BEEP_CYC (BCYC),
        .BUZZ_BEEPS    (BNUM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .workout_num (workout_num),
        .time_remain (time_remain),
        .buzzer      (buzzer),
        .seg         (seg),
        .an          (an),
        .buzz_out    (buzz_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // model state
    int k;
    int m_snap_w, m_snap_t, m_timer, m_disp_w, m_disp_t;
    int bz_start, bz_prev;
    bit prev_off;
    logic [6:0] m_seg;
    logic [4:0] m_an;
    logic       m_buzz, m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s k=%0d obs=%0h exp=%0h", tag, k, obs, exp_v);
        end
    endtask

    // Apply one clock edge worth of specified behaviour to the model
    task automatic model_step();
        int dig, d, n;
        bit blank, act;
        if (!reset) begin
            m_seg = 7'h7F; m_an = 5'h1F; m_buzz = 1'b0; m_busy = 1'b0;
            m_snap_w = 0; m_snap_t = 0; m_timer = 0; m_disp_w = 0; m_disp_t = 0;
            k = 0; bz_start = -1; bz_prev = 0; prev_off = 1'b0;
            return;
        end
        // scan output from the display contents before this edge
        dig = (k / CPD) % 5;
        blank = 1'b0;
        d = 0;
        case (dig)
            0: begin d = m_disp_w / 100;        blank = (m_disp_w < 100); end
            1: begin d = (m_disp_w / 10) % 10;  blank = (m_disp_w < 10);  end
            2: d = m_disp_w % 10;
            3: begin
                d = m_disp_t / 10;
`ifdef DISPLAY_ALARM_BLINK_EN
                blank = prev_off;
`endif
            end
            default: begin
                d = m_disp_t % 10;
`ifdef DISPLAY_ALARM_BLINK_EN
                blank = prev_off;
`endif
            end
        endcase
        m_seg = blank ? 7'h7F : seg_tbl[d];
        m_an  = 5'h1F & ~(5'd1 << dig);
        // conversion: capture on difference, display after fixed latency
        if (m_timer == 0) begin
            if (int'(workout_num) != m_snap_w || int'(time_remain) != m_snap_t) begin
                m_snap_w = int'(workout_num);
                m_snap_t = int'(time_remain);
                m_timer = CONV_LAT;
                m_busy = 1'b1;
            end
        end else begin
            m_timer--;
            if (m_timer == 0) begin
                m_disp_w = m_snap_w;
                m_disp_t = m_snap_t;
                m_busy = 1'b0;
            end
        end
        // buzzer: pattern position measured from the latest rising edge
        if (buzzer && bz_prev == 0) bz_start = k;
        bz_prev = int'(buzzer);
        n = k - bz_start;
        act = (bz_start >= 0) && (n < 2 * BNUM * BCYC);
        m_buzz = act && ((n % (2 * BCYC)) < BCYC);
        prev_off = act && !m_buzz;
        k++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("seg", 32'(seg), 32'(m_seg));
        chk("an", 32'(an), 32'(m_an));
        chk("buzz_out", 32'(buzz_out), 32'(m_buzz));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int dir_w [6] = '{157, 7, 100, 255, 10, 0};
    int dir_t [6] = '{42, 0, 9, 63, 5, 0};
    int busy_cnt;

    initial begin
        reset = 1'b0; workout_num = '0; time_remain = '0; buzzer = 1'b0;
        k = 0;
        // reset held for three edges
        run(3);
        reset = 1'b1;
        run(25);

        // directed values, each long enough to convert and scan all digits twice
        for (int i = 0; i < 6; i++) begin
            workout_num = 8'(dir_w[i]);
            time_remain = 6'(dir_t[i]);
            busy_cnt = 0;
            for (int j = 0; j < 60; j++) begin
                cyc();
                if (busy) busy_cnt++;
            end
            chk("busy_len", 32'(busy_cnt), (i == 5 && dir_w[4] == 0) ? 32'd0 : 32'(CONV_LAT));
        end

        // change during conversion: first value loads, then immediate reconversion
        workout_num = 8'd157; time_remain = 6'd42;
        run(5);
        workout_num = 8'd200;
        run(70);

        // held-high buzzer: one pattern, no retrigger
        buzzer = 1'b1;
        run(30);
        buzzer = 1'b0;
        run(5);

        // reset aborts a running pattern
        buzzer = 1'b1;
        run(5);
        reset = 1'b0; buzzer = 1'b0;
        run(1);
        reset = 1'b1;
        run(5);

        // second rising edge mid-pattern restarts it
        buzzer = 1'b1;
        run(7);
        buzzer = 1'b0;
        run(2);
        buzzer = 1'b1;
        run(25);
        buzzer = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) workout_num = 8'($urandom_range(255));
            if ($urandom_range(29) == 0) time_remain = 6'($urandom_range(63));
            if ($urandom_range(19) == 0) buzzer = ~buzzer;
            reset = ($urandom_range(499) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
